// File: rtl/axi4s_drv_pkg.sv
// Shared types and helpers for the AXI4-Stream operand/result driver.
package axi4s_drv_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, SEND = 2'd1, DROP = 2'd2, RECV = 2'd3} drv_state_t;

  function automatic int beats(input int sz, input int dsz);
    return 2 * sz / dsz;
  endfunction
endpackage

// File: rtl/stream_tx_shifter.sv
// Parallel-load shift register that serialises {b,a} into DSZ-bit beats, LSB first.
module stream_tx_shifter
  import axi4s_drv_pkg::*;
#(
  parameter int SZ  = 32,
  parameter int DSZ = 8
) (
  input  logic            clk,
  input  logic            _rst,
  input  logic            i_load,
  input  logic [2*SZ-1:0] i_data,
  input  logic            i_tready,
  output logic [DSZ-1:0]  o_tdata,
  output logic            o_tvalid,
  output logic            o_tlast,
  output logic            o_done
);
  localparam int N  = beats(SZ, DSZ);
  localparam int CW = $clog2(N) + 1;

  logic [2*SZ-1:0] r_sh;
  logic [CW-1:0]   r_cnt;
  logic [DSZ-1:0]  r_tdata;
  logic            r_tvalid;
  logic            r_tlast;
  logic            w_hs;

  assign w_hs     = r_tvalid & i_tready;
  assign o_done   = w_hs & r_tlast;
  assign o_tdata  = r_tdata;
  assign o_tvalid = r_tvalid;
  assign o_tlast  = r_tlast;

  // Beat 0 is presented straight from the load; the remainder shifts down.
  always_ff @(posedge clk or negedge _rst) begin
    if (!_rst) begin
      r_sh     <= '0;
      r_cnt    <= '0;
      r_tdata  <= '0;
      r_tvalid <= 1'b0;
      r_tlast  <= 1'b0;
    end else if (i_load) begin
      r_tdata  <= i_data[DSZ-1:0];
      r_sh     <= i_data >> DSZ;
      r_cnt    <= '0;
      r_tvalid <= 1'b1;
      r_tlast  <= (N == 1);
    end else if (w_hs) begin
      if (r_tlast) begin
        r_tdata  <= '0;
        r_tvalid <= 1'b0;
        r_tlast  <= 1'b0;
      end else begin
        r_tdata <= r_sh[DSZ-1:0];
        r_sh    <= r_sh >> DSZ;
        r_cnt   <= r_cnt + 1'b1;
        r_tlast <= (r_cnt == CW'(N - 2));
      end
    end
  end
endmodule

// File: rtl/axi4_stream_master_driver.sv
// AXI4-Stream initiator: sends {b,a} as one frame, drops stale result frames, assembles the next one.
module axi4_stream_master_driver
  import axi4s_drv_pkg::*;
#(
  parameter int SZ      = 32,
  parameter int DSZ     = 8,
  parameter int DISCARD = 1
) (
  input  logic            clk,
  input  logic            _rst,
  input  logic            start,
  input  logic [SZ-1:0]   a,
  input  logic [SZ-1:0]   b,
  output logic            busy,
  output logic [2*SZ-1:0] res,
  output logic            res_valid,
  output logic            err,
  output logic [DSZ-1:0]  tdata_to_slave,
  output logic            tvalid_to_slave,
  input  logic            tready_to_slave,
  output logic            tlast_to_slave,
  input  logic [DSZ-1:0]  tdata_to_master,
  input  logic            tvalid_to_master,
  output logic            tready_to_master,
  input  logic            tlast_to_master
);
  localparam int N  = beats(SZ, DSZ);
  localparam int KW = $clog2(N) + 1;
  localparam int DW = $clog2(DISCARD + 1) + 1;

  drv_state_t      r_state;
  logic            r_busy, r_err, r_res_valid, r_tready_m;
  logic [2*SZ-1:0] r_res, r_shadow;
  logic [KW-1:0]   r_k;
  logic [DW-1:0]   r_drop;

  logic            w_load, w_tx_done, w_rx_hs;
  logic [2*SZ-1:0] w_shadow;

  // busy is still high in the res_valid cycle, which makes start ignored there.
  assign w_load  = (r_state == IDLE) & start & ~r_busy;
  assign w_rx_hs = tvalid_to_master & r_tready_m;

  always_comb begin
    w_shadow = r_shadow;
    w_shadow[r_k*DSZ +: DSZ] = tdata_to_master;
  end

  stream_tx_shifter #(.SZ(SZ), .DSZ(DSZ)) u_tx (
    .clk      (clk),
    ._rst     (_rst),
    .i_load   (w_load),
    .i_data   ({b, a}),
    .i_tready (tready_to_slave),
    .o_tdata  (tdata_to_slave),
    .o_tvalid (tvalid_to_slave),
    .o_tlast  (tlast_to_slave),
    .o_done   (w_tx_done)
  );

  always_ff @(posedge clk or negedge _rst) begin
    if (!_rst) begin
      r_state     <= IDLE;
      r_busy      <= 1'b0;
      r_err       <= 1'b0;
      r_res_valid <= 1'b0;
      r_tready_m  <= 1'b0;
      r_res       <= '0;
      r_shadow    <= '0;
      r_k         <= '0;
      r_drop      <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (r_res_valid) begin
            r_res_valid <= 1'b0;
            r_busy      <= 1'b0;
          end else if (start) begin
            r_busy  <= 1'b1;
            r_err   <= 1'b0;
            r_state <= SEND;
          end
        end
        SEND: begin
          if (w_tx_done) begin
            r_tready_m <= 1'b1;
            r_k        <= '0;
            r_drop     <= '0;
            r_state    <= (DISCARD == 0) ? RECV : DROP;
          end
        end
        DROP: begin
          if (w_rx_hs && tlast_to_master) begin
            if (r_drop == DW'(DISCARD - 1)) r_state <= RECV;
            else r_drop <= r_drop + 1'b1;
          end
        end
        RECV: begin
          if (w_rx_hs) begin
            r_shadow <= w_shadow;
            if (tlast_to_master) begin
              if (r_k == KW'(N - 1)) begin
                r_res       <= w_shadow;
                r_res_valid <= 1'b1;
                r_tready_m  <= 1'b0;
                r_state     <= IDLE;
              end else begin
                r_err <= 1'b1;
                r_k   <= '0;
              end
            end else if (r_k == KW'(N - 1)) begin
              // Overlong frame: flag it and resync on the following frame.
              r_err <= 1'b1;
              r_k   <= '0;
            end else begin
              r_k <= r_k + 1'b1;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign busy             = r_busy;
  assign err              = r_err;
  assign res_valid        = r_res_valid;
  assign res              = r_res;
  assign tready_to_master = r_tready_m;
endmodule

// File: tb/tb_axi4_stream_master_driver.sv
// Directed bench: bench acts as a loopback multiplier slave for the driver.
module tb_axi4_stream_master_driver;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [31:0] a, b;
  logic        busy, res_valid, err;
  logic [63:0] res;
  logic [7:0]  tdata_s, tdata_m;
  logic        tvalid_s, tready_s, tlast_s;
  logic        tvalid_m, tready_m, tlast_m;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  axi4_stream_master_driver #(.SZ(32), .DSZ(8), .DISCARD(1)) dut (
    .clk              (clk),
    ._rst             (rst_n),
    .start            (start),
    .a                (a),
    .b                (b),
    .busy             (busy),
    .res              (res),
    .res_valid        (res_valid),
    .err              (err),
    .tdata_to_slave   (tdata_s),
    .tvalid_to_slave  (tvalid_s),
    .tready_to_slave  (tready_s),
    .tlast_to_slave   (tlast_s),
    .tdata_to_master  (tdata_m),
    .tvalid_to_master (tvalid_m),
    .tready_to_master (tready_m),
    .tlast_to_master  (tlast_m)
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    int          stall_beat;
    int          stall_len;
    bit          bad;
    bit          poke;
    bit          rv_start;
    logic [63:0] exp_res;
    bit          exp_err;
  } vec_t;

  vec_t tv[5];
  vec_t hv;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send_frame(input logic [63:0] d, input int nb, input int lastpos);
    for (int k = 0; k < nb; k++) begin
      int w;
      tvalid_m = 1'b1;
      tdata_m  = d[k*8 +: 8];
      tlast_m  = (k == lastpos);
      w = 0;
      while (!tready_m && w < 32) begin
        step();
        w++;
      end
      if (w == 32) chk("rx_tready_timeout", 64'(tready_m), 64'd1);
      step();
    end
    tvalid_m = 1'b0;
    tlast_m  = 1'b0;
    tdata_m  = '0;
  endtask

  task automatic run_txn(input vec_t v, input string tag);
    logic [63:0] ops, exp_ops, prod;
    int          i, cyc, stalled;
    bit          beat_ok;
    exp_ops = {v.b, v.a};
    ops     = '0;
    a = v.a; b = v.b; start = 1'b1;
    step();
    start = 1'b0;
    chk({tag, "_busy_on_start"}, 64'(busy), 64'd1);
    chk({tag, "_err_cleared"}, 64'(err), 64'd0);
    chk({tag, "_first_beat"}, {55'd0, tvalid_s, tdata_s}, {55'd0, 1'b1, exp_ops[7:0]});
    i = 0; cyc = 0; stalled = 0; beat_ok = 1'b1;
    while (i < 8 && cyc < 64) begin
      cyc++;
      if (v.poke && cyc == 2) begin start = 1'b1; a = 32'd9; end
      else begin start = 1'b0; a = v.a; end
      tready_s = !(i == v.stall_beat && stalled < v.stall_len);
      if (!tready_s) stalled++;
      if (!tvalid_s || tdata_s !== exp_ops[i*8 +: 8] || tlast_s !== (i == 7) || tready_m !== 1'b0)
        beat_ok = 1'b0;
      if (tready_s) begin
        ops[i*8 +: 8] = tdata_s;
        i++;
      end
      step();
    end
    start = 1'b0; a = v.a; tready_s = 1'b1;
    chk({tag, "_beats_stable"}, 64'(beat_ok), 64'd1);
    chk({tag, "_send_cycles"}, 64'(cyc), 64'(8 + v.stall_len));
    chk({tag, "_tvalid_after"}, {62'd0, tvalid_s, tlast_s}, 64'd0);
    prod = {32'd0, ops[31:0]} * {32'd0, ops[63:32]};
    send_frame({8{8'hEE}}, 8, 7);
    if (v.bad) begin
      send_frame({8{8'hA5}}, 5, 4);
      send_frame(64'h8877665544332211, 8, 7);
    end else begin
      send_frame(prod, 8, 7);
    end
    chk({tag, "_res_valid"}, {62'd0, res_valid, busy}, 64'd3);
    chk({tag, "_res"}, res, v.exp_res);
    chk({tag, "_err"}, 64'(err), 64'(v.exp_err));
    if (v.rv_start) begin
      start = 1'b1; a = 32'hDEAD; b = 32'hBEEF;
    end
    step();
    start = 1'b0;
    chk({tag, "_pulse_end"}, {61'd0, res_valid, busy, tvalid_s}, 64'd0);
    chk({tag, "_res_held"}, res, v.exp_res);
  endtask

  initial begin
    tv[0] = '{32'h3, 32'h5, -1, 0, 1'b0, 1'b0, 1'b0, 64'hF, 1'b0};
    tv[1] = '{32'hFFFFFFFF, 32'hFFFFFFFF, -1, 0, 1'b0, 1'b0, 1'b1, 64'hFFFFFFFE00000001, 1'b0};
    tv[2] = '{32'h01000007, 32'h10, 3, 4, 1'b0, 1'b0, 1'b0, 64'h10000070, 1'b0};
    tv[3] = '{32'h55, 32'h66, -1, 0, 1'b1, 1'b0, 1'b0, 64'h8877665544332211, 1'b1};
    tv[4] = '{32'h7, 32'h8, -1, 0, 1'b0, 1'b1, 1'b0, 64'h38, 1'b0};

    rst_n = 1'b1; start = 1'b0; a = '0; b = '0;
    tready_s = 1'b1; tvalid_m = 1'b0; tdata_m = '0; tlast_m = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("reset_outputs", {res[7:0], busy, res_valid, err, tvalid_s, tlast_s, tready_m, tdata_s},
        64'd0);
    step();
    rst_n = 1'b1;
    step();

    for (int t = 0; t < 5; t++) run_txn(tv[t], $sformatf("vec%0d", t));

    // Reset while beat 2 is on the bus must clear everything at once.
    a = 32'd7; b = 32'd9; start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    chk("pre_reset_beat2", {55'd0, tvalid_s, tdata_s}, {55'd0, 1'b1, 8'h00});
    rst_n = 1'b0;
    #1;
    chk("mid_reset_ctrl", {58'd0, busy, res_valid, err, tvalid_s, tlast_s, tready_m}, 64'd0);
    chk("mid_reset_data", {48'd0, tdata_s, 8'd0} | res, 64'd0);
    step();
    rst_n = 1'b1;
    step();
    hv = '{32'h2, 32'h3, -1, 0, 1'b0, 1'b0, 1'b0, 64'h6, 1'b0};
    run_txn(hv, "post_reset");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
